// File: rtl/mult_seq_if.sv
// Operand/result handshake bundle for mult_seq.
// The op_signed wire exists only when MULT_SIGNED_EN is defined.
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
`ifdef MULT_SIGNED_EN
    logic                 op_signed;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
`ifdef MULT_SIGNED_EN
        output op_signed,
`endif
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef MULT_SIGNED_EN
        input  op_signed,
`endif
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier consuming STEP multiplier bits per cycle.
// Optional two's-complement support is enabled by defining MULT_SIGNED_EN.
module mult_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic       clk,
    input  logic       rst,
    mult_seq_if.slave  bus
);
    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("mult_seq: illegal WIDTH/STEP combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;

    logic                 w_last;
    logic [2*WIDTH-1:0]   w_partial;
    logic [2*WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_neg;

`ifdef MULT_SIGNED_EN
    // Signed operands are multiplied as magnitudes; the sign is reapplied when loading DONE.
    always_comb begin
        w_neg   = 1'b0;
        w_a_mag = bus.a;
        w_b_mag = bus.b;
        if (bus.op_signed) begin
            w_neg = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            if (bus.a[WIDTH-1]) w_a_mag = -bus.a;
            if (bus.b[WIDTH-1]) w_b_mag = -bus.b;
        end
    end
`else
    assign w_neg   = 1'b0;
    assign w_a_mag = bus.a;
    assign w_b_mag = bus.b;
`endif

    // The multiplicand is pre-shifted each cycle, so no variable shifter is needed.
    assign w_partial = r_mcand * (2*WIDTH)'(r_mplier[STEP-1:0]);
    assign w_sum     = r_acc + w_partial;
    assign w_last    = (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next = BUSY;
            BUSY:    if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_neg    <= w_neg;
                    end
                end
                BUSY: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << STEP;
                    r_mplier <= r_mplier >> STEP;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) r_product <= r_neg ? -w_sum : w_sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.product   = r_product;
endmodule
